dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-ported data RAM between two masters: port 0 is the CPU
// load/store path, port 1 is a second master (debug loader / DMA). One access
// is issued per cycle; read data comes back with the RAM's one-cycle latency
// and is steered to whichever port issued the read.
//
// Arbitration is burst-limited round-robin: under contention the port that
// was granted last keeps winning until it has taken MAX_BURST consecutive
// grants, then the other port gets its turn. A lone requester is granted
// every cycle.
//
// Ports
//   I_clk, I_rst              clock, synchronous active-high reset
//   I_reqN/I_weN/I_addrN/     port N request (held until granted), write flag,
//   I_wdataN/I_wbeN           byte address, lane-aligned write data, lane enables
//   O_gntN                    port N accepted this cycle (combinational)
//   O_rvalidN/O_rdataN        port N read return (data is 0 when not valid)
//   O_mem_en/_we/_addr/       RAM access strobe and command
//   O_mem_wdata/_wbe
//   I_mem_rdata               RAM read data, valid one cycle after a read strobe
//   O_conflicts               saturating count of cycles with both requests high
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PRIORITY_PORT = 0,
    parameter int MAX_BURST     = 4
) (
    input  logic                    I_clk,
    input  logic                    I_rst,

    input  logic                    I_req0,
    input  logic                    I_we0,
    input  logic [ADDR_WIDTH-1:0]   I_addr0,
    input  logic [DATA_WIDTH-1:0]   I_wdata0,
    input  logic [DATA_WIDTH/8-1:0] I_wbe0,

    input  logic                    I_req1,
    input  logic                    I_we1,
    input  logic [ADDR_WIDTH-1:0]   I_addr1,
    input  logic [DATA_WIDTH-1:0]   I_wdata1,
    input  logic [DATA_WIDTH/8-1:0] I_wbe1,

    output logic                    O_gnt0,
    output logic                    O_gnt1,
    output logic                    O_rvalid0,
    output logic                    O_rvalid1,
    output logic [DATA_WIDTH-1:0]   O_rdata0,
    output logic [DATA_WIDTH-1:0]   O_rdata1,

    output logic                    O_mem_en,
    output logic                    O_mem_we,
    output logic [ADDR_WIDTH-1:0]   O_mem_addr,
    output logic [DATA_WIDTH-1:0]   O_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] O_mem_wbe,
    input  logic [DATA_WIDTH-1:0]   I_mem_rdata,

    output logic [15:0]             O_conflicts
);

    // Burst counter runs 0..MAX_BURST and saturates at MAX_BURST.
    localparam int                CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_BURST);
    localparam logic              LAST_RESET = (PRIORITY_PORT != 0);

    logic             last_q;       // port granted most recently
    logic [CNT_W-1:0] cnt_q;        // consecutive grants to last_q
    logic [1:0]       rd_pend_q;    // one-hot owner of the read returning now
    logic [15:0]      conflicts_q;

    // Requests are masked during reset so nothing is granted or issued to
    // the RAM in a reset cycle.
    logic req0_v;
    logic req1_v;
    logic any_req;
    logic both_req;
    logic win;                      // winning port index, meaningful when any_req

    assign req0_v   = I_req0 & ~I_rst;
    assign req1_v   = I_req1 & ~I_rst;
    assign any_req  = req0_v | req1_v;
    assign both_req = req0_v & req1_v;

    // Under contention the last winner keeps the RAM until its burst is used
    // up; a lone requester always wins. Depends only on requests and state,
    // never on I_mem_rdata.
    always_comb begin
        if (both_req) begin
            win = (cnt_q == CNT_MAX) ? ~last_q : last_q;
        end else begin
            win = req1_v;
        end
    end

    assign O_gnt0 = any_req & ~win;
    assign O_gnt1 = any_req &  win;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        O_mem_en    = 1'b0;
        O_mem_we    = 1'b0;
        O_mem_addr  = '0;
        O_mem_wdata = '0;
        O_mem_wbe   = '0;
        if (O_gnt0) begin
            O_mem_en    = 1'b1;
            O_mem_we    = I_we0;
            O_mem_addr  = I_addr0;
            O_mem_wdata = I_wdata0;
            O_mem_wbe   = I_wbe0;
        end else if (O_gnt1) begin
            O_mem_en    = 1'b1;
            O_mem_we    = I_we1;
            O_mem_addr  = I_addr1;
            O_mem_wdata = I_wdata1;
            O_mem_wbe   = I_wbe1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, and reset is checked inside the clocked
    // block because it is synchronous.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            last_q      <= LAST_RESET;
            cnt_q       <= '0;
            rd_pend_q   <= 2'b00;
            conflicts_q <= 16'd0;
        end else begin
            if (any_req) begin
                if (win == last_q) begin
                    cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    last_q <= win;
                    cnt_q  <= CNT_W'(1);
                end
            end

            // A read accepted now returns next cycle; writes never return.
            rd_pend_q <= {O_gnt1 & ~I_we1, O_gnt0 & ~I_we0};

            if (I_req0 && I_req1 && (conflicts_q != 16'hFFFF)) begin
                conflicts_q <= conflicts_q + 16'd1;
            end
        end
    end

    // A read granted just before reset is dropped: the return is masked in
    // the reset cycle and rd_pend is cleared at its edge.
    assign O_rvalid0   = rd_pend_q[0] & ~I_rst;
    assign O_rvalid1   = rd_pend_q[1] & ~I_rst;
    assign O_rdata0    = O_rvalid0 ? I_mem_rdata : '0;
    assign O_rdata1    = O_rvalid1 ? I_mem_rdata : '0;
    assign O_conflicts = I_rst ? 16'd0 : conflicts_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Two arbiters run side by side against their own behavioural RAMs:
//   u0: MAX_BURST=4, PRIORITY_PORT=0
//   u1: MAX_BURST=1, PRIORITY_PORT=1
// A reference model (run-length of consecutive grants, a plain word array for
// memory contents, a pending-read record) predicts grants, RAM commands, read
// returns and the conflict count every cycle. Directed scenarios add checks
// against fixed expected values.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        req0  [2];
    logic        we0   [2];
    logic [31:0] addr0 [2];
    logic [31:0] wdata0[2];
    logic [3:0]  wbe0  [2];
    logic        req1  [2];
    logic        we1   [2];
    logic [31:0] addr1 [2];
    logic [31:0] wdata1[2];
    logic [3:0]  wbe1  [2];

    logic        gnt0     [2];
    logic        gnt1     [2];
    logic        rvalid0  [2];
    logic        rvalid1  [2];
    logic [31:0] rdata0   [2];
    logic [31:0] rdata1   [2];
    logic        mem_en   [2];
    logic        mem_we   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [3:0]  mem_wbe  [2];
    logic [31:0] mem_rdata[2];
    logic [15:0] conflicts[2];

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_PORT(0), .MAX_BURST(4)) u0 (
        .I_clk(clk), .I_rst(rst),
        .I_req0(req0[0]), .I_we0(we0[0]), .I_addr0(addr0[0]), .I_wdata0(wdata0[0]), .I_wbe0(wbe0[0]),
        .I_req1(req1[0]), .I_we1(we1[0]), .I_addr1(addr1[0]), .I_wdata1(wdata1[0]), .I_wbe1(wbe1[0]),
        .O_gnt0(gnt0[0]), .O_gnt1(gnt1[0]),
        .O_rvalid0(rvalid0[0]), .O_rvalid1(rvalid1[0]),
        .O_rdata0(rdata0[0]), .O_rdata1(rdata1[0]),
        .O_mem_en(mem_en[0]), .O_mem_we(mem_we[0]), .O_mem_addr(mem_addr[0]),
        .O_mem_wdata(mem_wdata[0]), .O_mem_wbe(mem_wbe[0]), .I_mem_rdata(mem_rdata[0]),
        .O_conflicts(conflicts[0])
    );

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_PORT(1), .MAX_BURST(1)) u1 (
        .I_clk(clk), .I_rst(rst),
        .I_req0(req0[1]), .I_we0(we0[1]), .I_addr0(addr0[1]), .I_wdata0(wdata0[1]), .I_wbe0(wbe0[1]),
        .I_req1(req1[1]), .I_we1(we1[1]), .I_addr1(addr1[1]), .I_wdata1(wdata1[1]), .I_wbe1(wbe1[1]),
        .O_gnt0(gnt0[1]), .O_gnt1(gnt1[1]),
        .O_rvalid0(rvalid0[1]), .O_rvalid1(rvalid1[1]),
        .O_rdata0(rdata0[1]), .O_rdata1(rdata1[1]),
        .O_mem_en(mem_en[1]), .O_mem_we(mem_we[1]), .O_mem_addr(mem_addr[1]),
        .O_mem_wdata(mem_wdata[1]), .O_mem_wbe(mem_wbe[1]), .I_mem_rdata(mem_rdata[1]),
        .O_conflicts(conflicts[1])
    );

    // ---------------- behavioural RAM (one per instance) ----------------
    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;   // byte address 0x10
        if (i == 8) return 32'hFFFFFFFF;   // byte address 0x20
        return {8'hA5, 8'(i), 16'hC300 + 16'(i)};
    endfunction

    logic [31:0] ram [2][64];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 64; i++) ram[k][i] <= init_word(i);
            end else if (mem_en[k]) begin
                if (mem_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wbe[k][b])
                            ram[k][mem_addr[k][7:2]][b*8 +: 8] <= mem_wdata[k][b*8 +: 8];
                end else begin
                    mem_rdata[k] <= ram[k][mem_addr[k][7:2]];
                end
            end
        end
    end

    // ---------------- reference model ----------------
    int          max_b  [2] = '{4, 1};
    int          prio   [2] = '{0, 1};
    int          m_last [2] = '{0, 1};
    int          m_run  [2] = '{0, 0};
    int          m_pend [2] = '{-1, -1};
    logic [31:0] m_pdata[2];
    int          m_conf [2] = '{0, 0};
    logic [31:0] ref_mem[2][64];
    int          cur_w  [2];

    logic [1:0]  obs_gnt [2];
    logic        obs_rv0 [2];
    logic        obs_rv1 [2];
    logic [31:0] obs_rd0 [2];
    logic [15:0] obs_conf[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input int k, input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got %h expected %h (t=%0t)", k, tag, act, exp, $time);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the
    // rising edge, then release inputs for the next cycle.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic        s_we;
            logic [31:0] s_addr;
            logic [31:0] s_wdata;
            logic [3:0]  s_wbe;
            logic        e_rv0;
            logic        e_rv1;
            if (rst)                      w = -1;
            else if (req0[k] && req1[k])  w = (m_run[k] >= max_b[k]) ? 1 - m_last[k] : m_last[k];
            else if (req0[k])             w = 0;
            else if (req1[k])             w = 1;
            else                          w = -1;
            cur_w[k] = w;

            obs_gnt[k]  = {gnt1[k], gnt0[k]};
            obs_rv0[k]  = rvalid0[k];
            obs_rv1[k]  = rvalid1[k];
            obs_rd0[k]  = rdata0[k];
            obs_conf[k] = conflicts[k];

            check(k, "gnt0",   32'(gnt0[k]),   32'(w == 0));
            check(k, "gnt1",   32'(gnt1[k]),   32'(w == 1));
            check(k, "mem_en", 32'(mem_en[k]), 32'(w >= 0));
            if (w >= 0) begin
                s_we    = (w == 0) ? we0[k]    : we1[k];
                s_addr  = (w == 0) ? addr0[k]  : addr1[k];
                s_wdata = (w == 0) ? wdata0[k] : wdata1[k];
                s_wbe   = (w == 0) ? wbe0[k]   : wbe1[k];
                check(k, "mem_we",   32'(mem_we[k]), 32'(s_we));
                check(k, "mem_addr", mem_addr[k],    s_addr);
                if (s_we) begin
                    check(k, "mem_wdata", mem_wdata[k],     s_wdata);
                    check(k, "mem_wbe",   32'(mem_wbe[k]),  32'(s_wbe));
                end
            end

            e_rv0 = !rst && (m_pend[k] == 0);
            e_rv1 = !rst && (m_pend[k] == 1);
            check(k, "rvalid0", 32'(rvalid0[k]), 32'(e_rv0));
            check(k, "rvalid1", 32'(rvalid1[k]), 32'(e_rv1));
            check(k, "rdata0",  rdata0[k], e_rv0 ? m_pdata[k] : 32'd0);
            check(k, "rdata1",  rdata1[k], e_rv1 ? m_pdata[k] : 32'd0);
            check(k, "conflicts", 32'(conflicts[k]), rst ? 32'd0 : 32'(m_conf[k]));
        end

        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic        s_we;
            logic [31:0] s_addr;
            logic [31:0] s_wdata;
            logic [3:0]  s_wbe;
            int          idx;
            w = cur_w[k];
            if (rst) begin
                m_last[k] = prio[k];
                m_run[k]  = 0;
                m_pend[k] = -1;
                m_conf[k] = 0;
                for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
            end else begin
                if (req0[k] && req1[k] && m_conf[k] < 65535) m_conf[k]++;
                m_pend[k] = -1;
                if (w >= 0) begin
                    if (w == m_last[k]) m_run[k]++;
                    else begin
                        m_last[k] = w;
                        m_run[k]  = 1;
                    end
                    s_we    = (w == 0) ? we0[k]    : we1[k];
                    s_addr  = (w == 0) ? addr0[k]  : addr1[k];
                    s_wdata = (w == 0) ? wdata0[k] : wdata1[k];
                    s_wbe   = (w == 0) ? wbe0[k]   : wbe1[k];
                    idx     = int'(s_addr[7:2]);
                    if (s_we) begin
                        for (int b = 0; b < 4; b++)
                            if (s_wbe[b]) ref_mem[k][idx][b*8 +: 8] = s_wdata[b*8 +: 8];
                    end else begin
                        m_pend[k]  = w;
                        m_pdata[k] = ref_mem[k][idx];
                    end
                end
            end
        end
        #1;
    endtask

    // Drive one port identically on both instances.
    task automatic drive(input int p, input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        for (int k = 0; k < 2; k++) begin
            if (p == 0) begin
                req0[k] = r; we0[k] = we; addr0[k] = a; wdata0[k] = d; wbe0[k] = be;
            end else begin
                req1[k] = r; we1[k] = we; addr1[k] = a; wdata1[k] = d; wbe1[k] = be;
            end
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    // New random command unless an earlier request is still waiting.
    task automatic rand_stim(input int pct);
        for (int k = 0; k < 2; k++) begin
            if (!(req0[k] && cur_w[k] != 0)) begin
                req0[k]   = ($urandom_range(99) < pct);
                we0[k]    = 1'($urandom_range(1));
                addr0[k]  = 32'($urandom_range(15)) << 2;
                wdata0[k] = $urandom;
                wbe0[k]   = 4'($urandom_range(15));
            end
            if (!(req1[k] && cur_w[k] != 1)) begin
                req1[k]   = ($urandom_range(99) < pct);
                we1[k]    = 1'($urandom_range(1));
                addr1[k]  = 32'($urandom_range(15)) << 2;
                wdata1[k] = $urandom;
                wbe1[k]   = 4'($urandom_range(15));
            end
        end
    endtask

    int seq_u0[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int seq_u1[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        rst = 1'b1;
        idle();
        #1;
        step();
        do_reset();

        // Lone read of 0x10 returns DEADBEEF one cycle later on port 0.
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        step();
        check(0, "t1 gnt", 32'(obs_gnt[0]), 32'b01);
        idle();
        step();
        check(0, "t1 rvalid0", 32'(obs_rv0[0]), 32'd1);
        check(0, "t1 rdata0",  obs_rd0[0], 32'hDEADBEEF);
        check(0, "t1 rvalid1", 32'(obs_rv1[0]), 32'd0);

        // Continuous contention: bursts of MAX_BURST, conflict counting.
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h04, 32'd0, 4'd0);
        drive(1, 1'b1, 1'b0, 32'h08, 32'd0, 4'd0);
        for (int i = 0; i < 9; i++) begin
            step();
            check(0, "t2 seq", 32'(obs_gnt[0]), (seq_u0[i] == 0) ? 32'b01 : 32'b10);
            check(1, "t2 seq", 32'(obs_gnt[1]), (seq_u1[i] == 0) ? 32'b01 : 32'b10);
            if (i == 8) begin
                check(0, "t2 conflicts", 32'(obs_conf[0]), 32'd8);
                check(1, "t2 conflicts", 32'(obs_conf[1]), 32'd8);
            end
        end

        // MAX_BURST=1 alternation on competing writes.
        do_reset();
        drive(0, 1'b1, 1'b1, 32'h30, 32'hAAAAAAAA, 4'hF);
        drive(1, 1'b1, 1'b1, 32'h34, 32'h55555555, 4'hF);
        for (int i = 0; i < 6; i++) begin
            step();
            check(1, "t3 alt", 32'(obs_gnt[1]), (i % 2 == 0) ? 32'b10 : 32'b01);
        end
        idle();
        for (int k = 0; k < 2; k++) begin
            check(k, "t3 ram 0x30", ram[k][12], 32'hAAAAAAAA);
            check(k, "t3 ram 0x34", ram[k][13], 32'h55555555);
        end

        // Partial write then immediate read of the same word.
        do_reset();
        drive(1, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011);
        step();
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
        step();
        idle();
        step();
        check(0, "t4 rdata0", obs_rd0[0], 32'hFFFF5678);
        check(1, "t4 rdata0", obs_rd0[1], 32'hFFFF5678);

        // Reset lands on a pending read; a request during reset is ignored.
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        step();
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h14, 32'h01020304, 4'hF);
        drive(1, 1'b1, 1'b0, 32'h18, 32'd0, 4'd0);
        step();
        check(0, "t5 rst rvalid0", 32'(obs_rv0[0]), 32'd0);
        check(0, "t5 rst rdata0",  obs_rd0[0], 32'd0);
        check(0, "t5 rst gnt",     32'(obs_gnt[0]), 32'd0);
        rst = 1'b0;
        idle();
        step();
        check(0, "t5 post rvalid0", 32'(obs_rv0[0]), 32'd0);
        check(0, "t5 post rdata0",  obs_rd0[0], 32'd0);
        check(0, "t5 post conflicts", 32'(obs_conf[0]), 32'd0);
        drive(0, 1'b1, 1'b0, 32'h00, 32'd0, 4'd0);
        drive(1, 1'b1, 1'b0, 32'h04, 32'd0, 4'd0);
        step();
        check(0, "t5 first tie", 32'(obs_gnt[0]), 32'b01);
        check(1, "t5 first tie", 32'(obs_gnt[1]), 32'b10);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(199) == 0);
            rand_stim((i < 1000) ? 60 : 90);
            step();
        end
        rst = 1'b0;

        // Saturation of the conflict counter.
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h00, 32'd0, 4'd0);
        drive(1, 1'b1, 1'b0, 32'h3C, 32'd0, 4'd0);
        for (int i = 0; i < 70000; i++) step();
        check(0, "t6 saturate", 32'(obs_conf[0]), 32'h0000FFFF);
        check(1, "t6 saturate", 32'(obs_conf[1]), 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
